lstm_gate_scheduler: RTL

LSTM_GATE_SCHEDULER -- requirements
Module: lstm_gate_scheduler

---
 rtl/lstm_gate_scheduler_if.sv | 31 +++
 rtl/lstm_gate_scheduler.sv | 102 ++++++++++
 2 files changed

// File: rtl/lstm_gate_scheduler_if.sv
// ----------------------------------------------------------------------------
// lstm_gate_scheduler_if : handshake bundle between the LSTM gate scheduler
// and its MAC / activation units.  Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface lstm_gate_scheduler_if;
  logic       start;
  logic       mac_ack;
  logic       act_ack;
  logic       mac_clr;
  logic       mac_req;
  logic [3:0] in_idx;
  logic [1:0] gate_sel;
  logic [3:0] neuron_idx;
  logic       act_req;
  logic       busy;
  logic       done;

  modport master (
    input  start, mac_ack, act_ack,
    output mac_clr, mac_req, in_idx, gate_sel, neuron_idx, act_req, busy, done
  );

  modport slave (
    output start, mac_ack, act_ack,
    input  mac_clr, mac_req, in_idx, gate_sel, neuron_idx, act_req, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/lstm_gate_scheduler.sv
// ----------------------------------------------------------------------------
// lstm_gate_scheduler : sequences MAC and activation work over 4 gates and
// N_NEURON neurons for one LSTM layer pass.  Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module lstm_gate_scheduler #(
  parameter int N_IN     = 9,
  parameter int N_NEURON = 4
) (
  input  wire logic              clk,
  input  wire logic              rst,
  lstm_gate_scheduler_if.master  bus
);

  localparam logic [3:0] c_IN_LAST     = 4'(N_IN - 1);
  localparam logic [3:0] c_NEURON_LAST = 4'(N_NEURON - 1);
  localparam logic [1:0] c_GATE_LAST   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CLR  = 3'd1,
    S_MAC  = 3'd2,
    S_ACT  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t     r_state;
  logic [3:0] r_in_idx;
  logic [1:0] r_gate_sel;
  logic [3:0] r_neuron_idx;

  // All state moves on the falling edge; reset is asynchronous.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_in_idx     <= 4'd0;
      r_gate_sel   <= 2'd0;
      r_neuron_idx <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state      <= S_CLR;
            r_in_idx     <= 4'd0;
            r_gate_sel   <= 2'd0;
            r_neuron_idx <= 4'd0;
          end
        end
        S_CLR: begin
          r_state <= S_MAC;
        end
        S_MAC: begin
          if (bus.mac_ack) begin
            if (r_in_idx == c_IN_LAST) begin
              r_in_idx <= 4'd0;
              r_state  <= S_ACT;
            end else begin
              r_in_idx <= r_in_idx + 4'd1;
            end
          end
        end
        S_ACT: begin
          if (bus.act_ack) begin
            if (r_gate_sel != c_GATE_LAST) begin
              r_gate_sel <= r_gate_sel + 2'd1;
              r_state    <= S_CLR;
            end else begin
              r_gate_sel <= 2'd0;
              if (r_neuron_idx == c_NEURON_LAST) begin
                r_state <= S_DONE;
              end else begin
                r_neuron_idx <= r_neuron_idx + 4'd1;
                r_state      <= S_CLR;
              end
            end
          end
        end
        S_DONE: begin
          r_neuron_idx <= 4'd0;
          r_state      <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Strobes are pure decodes of the state register, so no input reaches an output.
  assign bus.mac_clr    = (r_state == S_CLR);
  assign bus.mac_req    = (r_state == S_MAC);
  assign bus.act_req    = (r_state == S_ACT);
  assign bus.done       = (r_state == S_DONE);
  assign bus.busy       = (r_state == S_CLR) || (r_state == S_MAC) || (r_state == S_ACT);
  assign bus.in_idx     = r_in_idx;
  assign bus.gate_sel   = r_gate_sel;
  assign bus.neuron_idx = r_neuron_idx;

endmodule

`default_nettype wire
